avmm_eval_sequencer: RTL
========================

# avmm_eval_sequencer

Hardware sequencer for the evaluation protocol of the AVMM program-logic slave. It replaces host-driven polling of that protocol with a local state machine. For one module id it drives continue/done/task/update accesses until the module settles or raises a task, then returns one response. It sits between the host command path and the program-logic Avalon-MM slave port, as that port's only master.

## Interface
- MAX_ITERS, 1024: watchdog limit on CONTINUE writes per command (used only when the watchdog is compiled in).
- GAP, 1: number of idle cycles forced between bus accesses; minimum 1.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when `cmd_valid & cmd_ready`.
- cmd_op  in  2  0=STEP, 1=RESUME, 2=ABORT, 3=OPEN_LOOP.
- cmd_mid  in  2  target module id.
- cmd_arg  in  32  OPEN_LOOP iteration count; ignored for other ops.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  2  0=DONE, 1=TASK, 2=TIMEOUT, 3=ABORTED.
- rsp_task  out  32  last TASK_ID read; 0 unless status is TASK.
- rsp_iters  out  16  CONTINUE writes issued for this command, saturating.
- m_address  out  16  {2'b00, mid, vid[11:0]}.
- m_read, m_write  out  1  bus strobes.
- m_writedata  out  32  write data.
- m_readdata  in  32  read data.
- m_waitrequest  in  1  slave stall.

## Operation
- Protocol vids: OPEN_LOOP=15, THERE_ARE_UPDATES=8, APPLY=9, DROP=10, TASK_ID=11, CONTINUE=12, RESET=13, DONE=14.
- Every protocol action is a write; the slave edge-detects the write strobe, so strobes deassert for GAP cycles between accesses.
- States: IDLE, CONT, RD_DONE, RD_TASK, RD_UPD, APPLY, OL_WR, OL_RD, AB_RST, AB_DROP, GAP, RESP. GAP records its return state.
- IDLE:
  - `cmd_ready=1`.
  - On accept, latch mid, op and arg, and clear the iteration counter.
  - STEP and RESUME go to CONT. ABORT goes to AB_RST. OPEN_LOOP goes to OL_WR.
- CONT: write CONTINUE (data 0), increment iters, then go to RD_DONE.
- RD_DONE:
  - Bit 0 set: go to RD_UPD.
  - Bit 0 clear: go to RD_TASK.
- RD_TASK:
  - Nonzero: latch it and respond TASK.
  - Zero: return to CONT.
- RD_UPD:
  - Nonzero: go to APPLY.
  - Zero: respond DONE.
- APPLY: write APPLY, then go to CONT, because applied updates may retrigger.
- OL_WR: write OPEN_LOOP with arg, then go to OL_RD.
- OL_RD: read OPEN_LOOP.
  - Zero: go to RD_UPD.
  - Nonzero: repeat OL_RD after GAP.
- AB_RST: write RESET, then go to AB_DROP.
- AB_DROP: write DROP, then respond ABORTED.
- RESP: assert rsp_valid for one cycle, then go to IDLE. Response fields hold until the next response.

## Timing
- Reset values:
  - All strobes 0, `m_address` 0, `m_writedata` 0.
  - `cmd_ready` 0, `rsp_valid` 0, `rsp_*` fields 0.
  - State IDLE.
  - `cmd_ready` rises on the first cycle after reset release.
- Bus phase:
  - Address, data and strobe are registered and held stable while `m_waitrequest=1`.
  - Readdata is sampled in the cycle waitrequest is low.
  - Strobes drop the next cycle.
- Minimum access: strobe assert, at least one waitrequest-high cycle (the slave registers waitrequest), one complete cycle, then GAP idle cycles.
- Commands presented while not in IDLE are not accepted; `cmd_ready=0`.
- A RESUME with no prior TASK behaves as STEP.
- `rsp_iters` saturates at 0xFFFF.
- If reset asserts mid-transaction, strobes drop asynchronously and the slave-side state is not repaired. The host must issue ABORT after reset release.

## Configuration
- `EVAL_SEQ_TIMEOUT_EN` defined:
  - Entering CONT with `iters==MAX_ITERS` skips the write and responds TIMEOUT.
  - TIMEOUT has `rsp_task=0` and no DROP.
- `EVAL_SEQ_TIMEOUT_EN` undefined: no limit, and status 2 is never produced.

## Structure
- Package `eval_seq_pkg`:
  - vid localparams.
  - `cmd_op_t` and `rsp_status_t` enums.
  - Address-packing function.
- Sub-module `avmm_single_xfer`:
  - Issues one read or write and holds it under waitrequest.
  - Returns `done` plus captured data, and enforces GAP.
- Top FSM sequences `avmm_single_xfer` only.

## Test plan
- STEP; slave returns DONE=1 on the first read and THERE_ARE_UPDATES=0 -> accesses CONTINUE, DONE, UPD; response DONE with iters=1.
- STEP; DONE=0, TASK_ID=0, then DONE=0, TASK_ID=7 -> two CONTINUEs; response TASK with task=7, iters=2. A following RESUME with DONE=1, UPD=0 -> DONE, iters=1.
- STEP; DONE=1, UPD=1, then DONE=1, UPD=0 -> APPLY written once, two CONTINUEs, response DONE.
- OPEN_LOOP arg=3; OPEN_LOOP reads 2, 1, 0, then UPD=0 -> OPEN_LOOP write data 3, three polls, response DONE with iters=0.
- ABORT with mid=2 -> writes to addresses 0x200D then 0x200A; response ABORTED. Reset pulsed mid-access -> strobes 0 immediately, `cmd_ready=1` after release.
- Timeout build with MAX_ITERS=4, DONE always 0, TASK always 0 -> exactly 4 CONTINUEs, response TIMEOUT.

Source files
------------

// File: rtl/avmm_eval_sequencer_pkg.sv
// eval_seq_pkg: shared definitions for the AVMM evaluation sequencer.
//   - protocol vid constants (12-bit, packed into the low address bits)
//   - cmd_op_t     : host command opcodes
//   - rsp_status_t : response status codes
//   - pack_addr()  : builds the slave address {2'b00, mid, vid}
package eval_seq_pkg;

    localparam logic [11:0] VID_THERE_ARE_UPDATES = 12'd8;
    localparam logic [11:0] VID_APPLY             = 12'd9;
    localparam logic [11:0] VID_DROP              = 12'd10;
    localparam logic [11:0] VID_TASK_ID           = 12'd11;
    localparam logic [11:0] VID_CONTINUE          = 12'd12;
    localparam logic [11:0] VID_RESET             = 12'd13;
    localparam logic [11:0] VID_DONE              = 12'd14;
    localparam logic [11:0] VID_OPEN_LOOP         = 12'd15;

    typedef enum logic [1:0] {
        OP_STEP      = 2'd0,
        OP_RESUME    = 2'd1,
        OP_ABORT     = 2'd2,
        OP_OPEN_LOOP = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_DONE    = 2'd0,
        ST_TASK    = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_ABORTED = 2'd3
    } rsp_status_t;

    function automatic logic [15:0] pack_addr(input logic [1:0] mid, input logic [11:0] vid);
        return {2'b00, mid, vid};
    endfunction

endpackage

// File: rtl/avmm_eval_sequencer_xfer.sv
// avmm_single_xfer: issues one Avalon-MM read or write at a time.
//   Parameters: GAP - idle cycles forced after each access (minimum 1).
//   Ports:
//     clk, reset          clock, asynchronous active-low reset
//     start               one-cycle request, honoured only while idle=1
//     is_write/addr/wdata access description, sampled with start
//     idle                ready for a new start (gap elapsed)
//     done, rdata         one-cycle completion pulse with captured readdata
//     m_*                 Avalon-MM master signals (registered)
// Strobes drop on the cycle after waitrequest is seen low; the slave
// edge-detects write strobes, so the gap guarantees a clean falling edge.
module avmm_single_xfer
    import eval_seq_pkg::*;
#(
    parameter int unsigned GAP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_write,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        idle,
    output logic        done,
    output logic [31:0] rdata,
    output logic [15:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest
);

    typedef enum logic [1:0] {
        X_IDLE,
        X_BUS,
        X_GAP
    } xstate_t;

    xstate_t     xs;
    logic [15:0] gap_cnt;

    assign idle = (xs == X_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xs          <= X_IDLE;
            gap_cnt     <= '0;
            done        <= 1'b0;
            rdata       <= '0;
            m_address   <= '0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_writedata <= '0;
        end else begin
            done <= 1'b0;
            case (xs)
                X_IDLE: begin
                    if (start) begin
                        m_address   <= addr;
                        m_writedata <= is_write ? wdata : '0;
                        m_write     <= is_write;
                        m_read      <= !is_write;
                        xs          <= X_BUS;
                    end
                end
                X_BUS: begin
                    if (!m_waitrequest) begin
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        rdata   <= m_readdata;
                        done    <= 1'b1;
                        gap_cnt <= 16'(GAP - 1);
                        xs      <= X_GAP;
                    end
                end
                X_GAP: begin
                    if (gap_cnt == '0) begin
                        xs <= X_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: xs <= X_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/avmm_eval_sequencer.sv
// avmm_eval_sequencer: runs the program-logic evaluation protocol for one
// module id per command and returns a single response.
//   Parameters: MAX_ITERS - CONTINUE limit per command (watchdog builds only)
//               GAP       - idle cycles between bus accesses (minimum 1)
//   Ports:
//     clk, reset                        clock, asynchronous active-low reset
//     cmd_valid/cmd_ready               command handshake
//     cmd_op, cmd_mid, cmd_arg          opcode, module id, OPEN_LOOP count
//     rsp_valid                         one-cycle response pulse
//     rsp_status, rsp_task, rsp_iters   response fields (held until next)
//     m_address, m_read, m_write,
//     m_writedata, m_readdata,
//     m_waitrequest                     Avalon-MM master to the slave
//   Build option: EVAL_SEQ_TIMEOUT_EN enables the MAX_ITERS watchdog.
module avmm_eval_sequencer
    import eval_seq_pkg::*;
#(
    parameter int unsigned MAX_ITERS = 1024,
    parameter int unsigned GAP       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_mid,
    input  logic [31:0] cmd_arg,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_task,
    output logic [15:0] rsp_iters,
    output logic [15:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest
);

`ifdef EVAL_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_CONT,
        S_RD_DONE,
        S_RD_TASK,
        S_RD_UPD,
        S_APPLY,
        S_OL_WR,
        S_OL_RD,
        S_AB_RST,
        S_AB_DROP,
        S_GAP,
        S_RESP
    } state_t;

    state_t      state;
    state_t      gap_ret;
    logic        issued;
    logic [1:0]  mid_q;
    logic [31:0] arg_q;
    logic [15:0] iters;

    logic        x_start;
    logic        x_is_write;
    logic [15:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_idle;
    logic        x_done;
    logic [31:0] x_rdata;

    logic [11:0] acc_vid;
    logic        acc_write;
    logic [31:0] acc_wdata;

    // Access issued by each bus state.
    always_comb begin
        acc_vid   = VID_CONTINUE;
        acc_write = 1'b0;
        acc_wdata = '0;
        case (state)
            S_CONT:    begin acc_vid = VID_CONTINUE;  acc_write = 1'b1; end
            S_RD_DONE: acc_vid = VID_DONE;
            S_RD_TASK: acc_vid = VID_TASK_ID;
            S_RD_UPD:  acc_vid = VID_THERE_ARE_UPDATES;
            S_APPLY:   begin acc_vid = VID_APPLY;     acc_write = 1'b1; end
            S_OL_WR:   begin acc_vid = VID_OPEN_LOOP; acc_write = 1'b1; acc_wdata = arg_q; end
            S_OL_RD:   acc_vid = VID_OPEN_LOOP;
            S_AB_RST:  begin acc_vid = VID_RESET;     acc_write = 1'b1; end
            S_AB_DROP: begin acc_vid = VID_DROP;      acc_write = 1'b1; end
            default:   ;
        endcase
    end

    // Bus states share one pattern: issue once when the transfer engine is
    // idle, wait for done, then either respond or park in S_GAP with the
    // next state in gap_ret until the engine's gap has elapsed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            gap_ret    <= S_IDLE;
            issued     <= 1'b0;
            mid_q      <= '0;
            arg_q      <= '0;
            iters      <= '0;
            x_start    <= 1'b0;
            x_is_write <= 1'b0;
            x_addr     <= '0;
            x_wdata    <= '0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
            rsp_task   <= '0;
            rsp_iters  <= '0;
        end else begin
            x_start   <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        mid_q     <= cmd_mid;
                        arg_q     <= cmd_arg;
                        iters     <= '0;
                        case (cmd_op_t'(cmd_op))
                            OP_ABORT:     state <= S_AB_RST;
                            OP_OPEN_LOOP: state <= S_OL_WR;
                            default:      state <= S_CONT;
                        endcase
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (x_idle) begin
                        state <= gap_ret;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    if (!issued) begin
                        if (TIMEOUT_EN && state == S_CONT && 32'(iters) == MAX_ITERS) begin
                            state      <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= ST_TIMEOUT;
                            rsp_task   <= '0;
                            rsp_iters  <= iters;
                        end else if (x_idle) begin
                            x_start    <= 1'b1;
                            issued     <= 1'b1;
                            x_addr     <= pack_addr(mid_q, acc_vid);
                            x_is_write <= acc_write;
                            x_wdata    <= acc_wdata;
                        end
                    end else if (x_done) begin
                        issued <= 1'b0;
                        state  <= S_GAP;
                        case (state)
                            S_CONT: begin
                                iters   <= (iters == 16'hFFFF) ? iters : iters + 16'd1;
                                gap_ret <= S_RD_DONE;
                            end
                            S_RD_DONE: gap_ret <= x_rdata[0] ? S_RD_UPD : S_RD_TASK;
                            S_RD_TASK: begin
                                if (x_rdata != '0) begin
                                    state      <= S_RESP;
                                    rsp_valid  <= 1'b1;
                                    rsp_status <= ST_TASK;
                                    rsp_task   <= x_rdata;
                                    rsp_iters  <= iters;
                                end else begin
                                    gap_ret <= S_CONT;
                                end
                            end
                            S_RD_UPD: begin
                                if (x_rdata != '0) begin
                                    gap_ret <= S_APPLY;
                                end else begin
                                    state      <= S_RESP;
                                    rsp_valid  <= 1'b1;
                                    rsp_status <= ST_DONE;
                                    rsp_task   <= '0;
                                    rsp_iters  <= iters;
                                end
                            end
                            S_APPLY:  gap_ret <= S_CONT;
                            S_OL_WR:  gap_ret <= S_OL_RD;
                            S_OL_RD:  gap_ret <= (x_rdata == '0) ? S_RD_UPD : S_OL_RD;
                            S_AB_RST: gap_ret <= S_AB_DROP;
                            S_AB_DROP: begin
                                state      <= S_RESP;
                                rsp_valid  <= 1'b1;
                                rsp_status <= ST_ABORTED;
                                rsp_task   <= '0;
                                rsp_iters  <= iters;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    avmm_single_xfer #(
        .GAP(GAP)
    ) u_xfer (
        .clk          (clk),
        .reset        (reset),
        .start        (x_start),
        .is_write     (x_is_write),
        .addr         (x_addr),
        .wdata        (x_wdata),
        .idle         (x_idle),
        .done         (x_done),
        .rdata        (x_rdata),
        .m_address    (m_address),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest)
    );

endmodule
